instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/fetch_pkg.sv | 15 +
 rtl/instruction_fetch_if.sv | 44 ++++
 rtl/fetch_pc_reg.sv | 40 ++++
 rtl/instruction_fetch.sv | 115 +++++++++++
 tb/tb_instruction_fetch.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

    localparam int DEF_INS_ADDRESS = 9;
    localparam int DEF_INS_W       = 32;
    localparam int PC_INC          = 4;
    localparam logic [15:0] FETCH_COUNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - memory, redirect and IF/ID bundle of the fetch stage
interface instruction_fetch_if #(
    parameter int INS_ADDRESS = fetch_pkg::DEF_INS_ADDRESS,
    parameter int INS_W       = fetch_pkg::DEF_INS_W
) ();

    logic [INS_ADDRESS-1:0] imem_ra;
    logic [INS_W-1:0]       imem_rd;
    logic                   redirect_valid;
    logic [INS_ADDRESS-1:0] redirect_pc;
    logic                   out_valid;
    logic                   out_ready;
    logic [INS_ADDRESS-1:0] out_pc;
    logic [INS_W-1:0]       out_instr;
    logic                   fault;
    logic [15:0]            fetch_count;

    modport master (
        output imem_ra,
        input  imem_rd,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_instr,
        output fault,
        output fetch_count
    );

    modport slave (
        input  imem_ra,
        output imem_rd,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_instr,
        input  fault,
        input  fetch_count
    );

endinterface

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - program counter with wrapping increment and redirect load
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter int INS_ADDRESS = DEF_INS_ADDRESS,
    parameter int RESET_PC    = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load_en_i,
    input  logic [INS_ADDRESS-1:0] load_pc_i,
    input  logic                   inc_en_i,
    output logic [INS_ADDRESS-1:0] pc_o
);

    logic [INS_ADDRESS-1:0] pc_q;
    logic [INS_ADDRESS-1:0] pc_d;

    // Load beats increment; the add is width-truncated so it wraps to zero at the top.
    always_comb begin
        pc_d = pc_q;
        if (load_en_i) begin
            pc_d = load_pc_i;
        end else if (inc_en_i) begin
            pc_d = pc_q + INS_ADDRESS'(PC_INC);
        end
    end

    // PC register, reset to the boot address.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= INS_ADDRESS'(RESET_PC);
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch FSM and IF/ID register in front of an external instruction memory
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int INS_ADDRESS = DEF_INS_ADDRESS,
    parameter int INS_W       = DEF_INS_W,
    parameter int RESET_PC    = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    instruction_fetch_if.master bus
);

    fetch_state_e           state_q, state_d;
    logic                   out_valid_q, out_valid_d;
    logic [INS_ADDRESS-1:0] out_pc_q, out_pc_d;
    logic [INS_W-1:0]       out_instr_q, out_instr_d;
    logic                   fault_q, fault_d;
    logic [15:0]            count_q, count_d;

    logic [INS_ADDRESS-1:0] pc;
    logic                   pc_load;
    logic                   pc_inc;
    logic                   redirect_aligned;

    assign redirect_aligned = (bus.redirect_pc[1:0] == 2'b00);

    fetch_pc_reg #(
        .INS_ADDRESS (INS_ADDRESS),
        .RESET_PC    (RESET_PC)
    ) u_pc (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_en_i (pc_load),
        .load_pc_i (bus.redirect_pc),
        .inc_en_i  (pc_inc),
        .pc_o      (pc)
    );

    // Next state: redirects win over fetch/stall; a misaligned target parks the stage in HALT.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_instr_d = out_instr_q;
        fault_d     = fault_q;
        pc_load     = 1'b0;
        pc_inc      = 1'b0;

        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (bus.redirect_valid) begin
                    out_valid_d = 1'b0;
                    if (redirect_aligned) begin
                        pc_load = 1'b1;
                        state_d = ST_RUN;
                    end else begin
                        fault_d = 1'b1;
                        state_d = ST_HALT;
                    end
                end else if (state_q == ST_IDLE) begin
                    state_d = ST_RUN;
                end else if (!out_valid_q || bus.out_ready) begin
                    out_pc_d    = pc;
                    out_instr_d = bus.imem_rd;
                    out_valid_d = 1'b1;
                    pc_inc      = 1'b1;
                end
            end
            ST_HALT: begin
                out_valid_d = 1'b0;
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // Count accepted handoffs; a redirect in the same cycle flushes the entry instead.
    always_comb begin
        count_d = count_q;
        if (out_valid_q && bus.out_ready && !bus.redirect_valid &&
            (count_q != FETCH_COUNT_MAX)) begin
            count_d = count_q + 16'd1;
        end
    end

    // State, IF/ID register, sticky fault and handoff counter; reset overrides everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_instr_q <= '0;
            fault_q     <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_instr_q <= out_instr_d;
            fault_q     <= fault_d;
            count_q     <= count_d;
        end
    end

    assign bus.imem_ra     = pc;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_pc      = out_pc_q;
    assign bus.out_instr   = out_instr_q;
    assign bus.fault       = fault_q;
    assign bus.fetch_count = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - scoreboard bench for instruction_fetch
module tb_instruction_fetch;

    logic clk;
    logic rst_n;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];

    instruction_fetch_if #(.INS_ADDRESS(9), .INS_W(32)) bus ();

    instruction_fetch #(
        .INS_ADDRESS (9),
        .INS_W       (32),
        .RESET_PC    (0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [31:0] word(input int addr);
        return 32'h1000_0000 + 32'(addr / 4);
    endfunction

    assign bus.imem_rd = word(int'(bus.imem_ra));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int addr);
        exp_t e;
        e.pc    = 32'(addr);
        e.instr = word(addr);
        exp_q.push_back(e);
    endtask

    // Monitor: every accepted handoff (not flushed by a redirect) must match the next expected entry.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && bus.out_ready && !bus.redirect_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_handoff_pc", 32'(bus.out_pc), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("handoff_pc", 32'(bus.out_pc), e.pc);
                    check("handoff_instr", bus.out_instr, e.instr);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n              = 1'b0;
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        tick();
        tick();

        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_pc", 32'(bus.out_pc), 32'd0);
        check("rst_out_instr", bus.out_instr, 32'd0);
        check("rst_fault", 32'(bus.fault), 32'd0);
        check("rst_count", 32'(bus.fetch_count), 32'd0);
        check("rst_imem_ra", 32'(bus.imem_ra), 32'd0);

        rst_n = 1'b1;
        push(0); push(4); push(8);
        tick();
        check("idle_out_valid", 32'(bus.out_valid), 32'd0);
        check("idle_imem_ra", 32'(bus.imem_ra), 32'd0);
        tick();
        check("first_valid", 32'(bus.out_valid), 32'd1);
        check("first_pc", 32'(bus.out_pc), 32'd0);
        check("first_count", 32'(bus.fetch_count), 32'd0);
        tick();
        check("count_1", 32'(bus.fetch_count), 32'd1);
        tick();
        check("count_2", 32'(bus.fetch_count), 32'd2);
        check("pc_8", 32'(bus.out_pc), 32'd8);

        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc", 32'(bus.out_pc), 32'd8);
            check("stall_instr", bus.out_instr, word(8));
            check("stall_imem_ra", 32'(bus.imem_ra), 32'd12);
            check("stall_count", 32'(bus.fetch_count), 32'd2);
        end
        bus.out_ready = 1'b1;
        tick();
        check("release_pc", 32'(bus.out_pc), 32'd12);
        check("release_count", 32'(bus.fetch_count), 32'd3);

        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 9'h040;
        tick();
        check("redir_out_valid", 32'(bus.out_valid), 32'd0);
        check("redir_imem_ra", 32'(bus.imem_ra), 32'h40);
        check("redir_count", 32'(bus.fetch_count), 32'd3);
        bus.redirect_valid = 1'b0;
        bus.out_ready      = 1'b1;
        push(32'h40);
        tick();
        check("redir_target_pc", 32'(bus.out_pc), 32'h40);
        check("redir_target_valid", 32'(bus.out_valid), 32'd1);
        tick();
        check("count_4", 32'(bus.fetch_count), 32'd4);
        check("pc_44", 32'(bus.out_pc), 32'h44);

        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 9'h1F8;
        push(32'h1F8); push(32'h1FC); push(0);
        tick();
        check("flush_valid", 32'(bus.out_valid), 32'd0);
        check("flush_imem_ra", 32'(bus.imem_ra), 32'h1F8);
        check("flush_count", 32'(bus.fetch_count), 32'd4);
        bus.redirect_valid = 1'b0;
        tick();
        check("wrap_pc_504", 32'(bus.out_pc), 32'h1F8);
        tick();
        check("wrap_pc_508", 32'(bus.out_pc), 32'h1FC);
        check("wrap_imem_ra", 32'(bus.imem_ra), 32'd0);
        tick();
        check("wrap_pc_0", 32'(bus.out_pc), 32'd0);
        check("wrap_fault", 32'(bus.fault), 32'd0);
        check("count_6", 32'(bus.fetch_count), 32'd6);
        tick();
        check("count_7", 32'(bus.fetch_count), 32'd7);
        check("pc_4", 32'(bus.out_pc), 32'd4);

        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 9'h042;
        tick();
        check("halt_fault", 32'(bus.fault), 32'd1);
        check("halt_valid", 32'(bus.out_valid), 32'd0);
        check("halt_imem_ra", 32'(bus.imem_ra), 32'd8);
        check("halt_count", 32'(bus.fetch_count), 32'd7);
        bus.redirect_pc = 9'h010;
        bus.out_ready   = 1'b1;
        tick();
        check("halt_ignore_ra", 32'(bus.imem_ra), 32'd8);
        check("halt_ignore_valid", 32'(bus.out_valid), 32'd0);
        check("halt_sticky_fault", 32'(bus.fault), 32'd1);
        bus.redirect_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        check("halt_rst_fault", 32'(bus.fault), 32'd0);
        check("halt_rst_ra", 32'(bus.imem_ra), 32'd0);
        check("halt_rst_count", 32'(bus.fetch_count), 32'd0);
        check("halt_rst_valid", 32'(bus.out_valid), 32'd0);

        rst_n         = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        tick();
        check("refetch_valid", 32'(bus.out_valid), 32'd1);
        check("refetch_pc", 32'(bus.out_pc), 32'd0);
        tick();
        rst_n              = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 9'h080;
        tick();
        check("rstredir_ra", 32'(bus.imem_ra), 32'd0);
        check("rstredir_valid", 32'(bus.out_valid), 32'd0);
        check("rstredir_pc", 32'(bus.out_pc), 32'd0);
        check("rstredir_count", 32'(bus.fetch_count), 32'd0);
        rst_n              = 1'b1;
        bus.redirect_valid = 1'b0;
        tick();
        check("rstredir_idle_valid", 32'(bus.out_valid), 32'd0);
        check("rstredir_idle_ra", 32'(bus.imem_ra), 32'd0);
        tick();
        check("rstredir_run_valid", 32'(bus.out_valid), 32'd1);
        check("rstredir_run_pc", 32'(bus.out_pc), 32'd0);
        check("rstredir_run_ra", 32'(bus.imem_ra), 32'd4);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
